// File: rtl/shrimp_pkg.sv
// Shared types and constants for the SHRIMP instruction fetch slice.
package shrimp_pkg;

  localparam int FETCH_DEPTH = 2;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] instr_t;
  typedef logic [1:0]  count_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/shrimp_fetch_buffer.sv
// Two-entry FIFO holding fetched instructions and their addresses.
module shrimp_fetch_buffer
  import shrimp_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  addr_t  push_addr,
  input  instr_t push_data,
  output count_t count,
  output instr_t head_data,
  output addr_t  head_addr
);

  instr_t data_q [FETCH_DEPTH];
  instr_t data_d [FETCH_DEPTH];
  addr_t  addr_q [FETCH_DEPTH];
  addr_t  addr_d [FETCH_DEPTH];
  logic   rd_ptr_q, rd_ptr_d;
  logic   wr_ptr_q, wr_ptr_d;
  count_t count_q, count_d;
  logic   do_push, do_pop;

  always_comb begin
    data_d   = data_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & (count_q != 2'd0);
    do_push  = push & ((count_q < count_t'(FETCH_DEPTH)) | do_pop);

    // Flush only resets the pointers; stale storage is unreachable once empty.
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        data_d[wr_ptr_q] = push_data;
        addr_d[wr_ptr_q] = push_addr;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + count_t'(do_push) - count_t'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = data_q[rd_ptr_q];
  assign head_addr = addr_q[rd_ptr_q];

endmodule

// File: rtl/shrimp_instruction_fetch.sv
// Instruction fetch: issues word-aligned memory reads, buffers results, handles redirects.
module shrimp_instruction_fetch
  import shrimp_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  addr_t  instruction_address,
  input  logic   jump,
  output logic   fetch_next,
  output logic   mem_req,
  output addr_t  mem_addr,
  input  logic   mem_ack,
  input  instr_t mem_rdata,
  output instr_t instr,
  output addr_t  instr_addr,
  output logic   instr_valid,
  input  logic   instr_ready
);

  fetch_state_t state_q, state_d;
  addr_t        hold_addr_q, hold_addr_d;
  addr_t        pc_addr;
  count_t       count, count_after;
  logic         req_active, handshake, push, pop, space;

  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    pc_addr     = word_align(instruction_address);
    req_active  = (state_q != IDLE);
    handshake   = req_active & mem_ack;
    push        = handshake & (state_q == REQ) & ~jump & ~reset;
    pop         = instr_valid & instr_ready;

    if (jump) begin
      count_after = 2'd0;
    end else begin
      count_after = count + count_t'(push) - count_t'(pop);
    end
    space = (count_after < count_t'(FETCH_DEPTH));

    case (state_q)
      IDLE: begin
        if (space) state_d = REQ;
      end
      REQ: begin
        if (jump) begin
          if (mem_ack) begin
            state_d = REQ;
          end else begin
            // The counter moves to the target now; keep presenting the old address.
            state_d     = DISCARD;
            hold_addr_d = pc_addr;
          end
        end else if (mem_ack) begin
          state_d = space ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (mem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign mem_req     = req_active & ~reset;
  assign mem_addr    = (state_q == DISCARD) ? hold_addr_q : pc_addr;
  assign fetch_next  = push;
  assign instr_valid = (count != 2'd0);

  shrimp_fetch_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (jump),
    .push_addr (pc_addr),
    .push_data (mem_rdata),
    .count     (count),
    .head_data (instr),
    .head_addr (instr_addr)
  );

endmodule

// File: tb/tb_shrimp_instruction_fetch.sv
// Directed and randomized bench for shrimp_instruction_fetch with a queue-based reference model.
module tb_shrimp_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction_address;
  logic        jump;
  logic        fetch_next;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  shrimp_instruction_fetch dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .jump                (jump),
    .fetch_next          (fetch_next),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .instr               (instr),
    .instr_addr          (instr_addr),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] align16(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

  assign mem_rdata = memf(mem_addr);

  int          compared = 0;
  int          mismatched = 0;
  int          consumed = 0;
  logic [31:0] q [$];
  logic        pending_drop = 1'b0;
  logic        req_hold = 1'b0;
  logic        prev_reset = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  logic [15:0] pc_nxt = 16'h0;
  logic [15:0] jump_target = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle, compare with the model, and advance the model.
  task automatic sample();
    logic exp_valid, hs, exp_fn, pop;
    @(negedge clock);
    pc_nxt = instruction_address;
    if (reset) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_fetch_next", fetch_next, 0);
      if (prev_reset) begin
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_addr", instr_addr, 0);
      end
      q.delete();
      pending_drop = 1'b0;
      req_hold     = 1'b0;
      prev_reset   = 1'b1;
    end else begin
      exp_valid = (q.size() != 0);
      check("instr_valid", instr_valid, exp_valid);
      if (exp_valid) begin
        check("instr_addr", instr_addr, q[0][31:16]);
        check("instr", instr, q[0][15:0]);
      end
      if (req_hold) begin
        check("req_held", mem_req, 1);
        check("addr_held", mem_addr, hold_addr);
      end
      hs     = mem_req & mem_ack;
      exp_fn = hs & ~jump & ~pending_drop;
      check("fetch_next", fetch_next, exp_fn);
      if (exp_fn) check("fetch_addr", mem_addr, align16(instruction_address));
      pop = exp_valid & instr_ready;
      if (pop) consumed++;
      if (jump) begin
        q.delete();
        pending_drop = mem_req & ~mem_ack;
        pc_nxt       = jump_target;
      end else begin
        if (pop) void'(q.pop_front());
        if (hs & ~pending_drop) begin
          q.push_back({align16(instruction_address), memf(align16(instruction_address))});
          pc_nxt = instruction_address + 16'd2;
          check("occupancy_le2", q.size() <= 2, 1);
        end
        pending_drop = pending_drop & ~hs;
      end
      req_hold   = mem_req & ~mem_ack;
      hold_addr  = mem_addr;
      prev_reset = 1'b0;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    instruction_address = pc_nxt;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset(input logic [15:0] pc_start);
    reset = 1'b1;
    jump  = 1'b0;
    instruction_address = pc_start;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; jump = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    instruction_address = 16'h0;

    // Streaming at full rate from PC 0, including reset-release latency.
    do_reset(16'h0000);
    mem_ack = 1'b1; instr_ready = 1'b1;
    sample(); check("lat_idle_no_req", mem_req, 0); advance();
    sample(); check("lat_first_req", mem_req, 1); check("lat_valid_low", instr_valid, 0);
    check("stream_fn_first", fetch_next, 1); advance();
    for (int i = 0; i < 4; i++) begin
      sample();
      check("stream_addr", instr_addr, 32'(i * 2));
      check("stream_fn", fetch_next, 1);
      advance();
    end

    // Stalled decoder: two fetches fill the buffer, then requests stop.
    do_reset(16'h0000);
    mem_ack = 1'b1; instr_ready = 1'b0;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("full_no_req", mem_req, 0);
      check("full_valid", instr_valid, 1);
      check("full_instr", instr, memf(16'h0000));
      check("full_addr", instr_addr, 0);
      advance();
    end

    // Slow memory: request held three cycles at 0x0010.
    do_reset(16'h0010);
    mem_ack = 1'b0; instr_ready = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, 16'h0010);
      check("wait_fn", fetch_next, 0);
      advance();
    end
    mem_ack = 1'b1;
    sample(); check("wait_ack_fn", fetch_next, 1); advance();
    mem_ack = 1'b0;
    sample(); check("wait_valid", instr_valid, 1); check("wait_iaddr", instr_addr, 16'h0010);
    check("wait_instr", instr, memf(16'h0010)); advance();

    // Jump with an outstanding request: returned data must be discarded.
    do_reset(16'h0000);
    mem_ack = 1'b0; instr_ready = 1'b1;
    cyc(); cyc();
    jump = 1'b1; jump_target = 16'd120;
    sample(); check("disc_jump_fn", fetch_next, 0); advance();
    jump = 1'b0; mem_ack = 1'b1;
    sample(); check("disc_req", mem_req, 1); check("disc_fn", fetch_next, 0);
    check("disc_valid", instr_valid, 0); advance();
    sample(); check("disc_new_addr", mem_addr, 16'd120); check("disc_new_fn", fetch_next, 1); advance();
    sample(); check("disc_iaddr", instr_addr, 16'd120); check("disc_ivalid", instr_valid, 1); advance();

    // Jump coinciding with ack while one entry is buffered.
    do_reset(16'h0000);
    mem_ack = 1'b1; instr_ready = 1'b0;
    cyc(); cyc();
    jump = 1'b1; jump_target = 16'h0200;
    sample(); check("jack_valid_before", instr_valid, 1); check("jack_fn", fetch_next, 0); advance();
    jump = 1'b0;
    sample(); check("jack_flushed", instr_valid, 0); check("jack_addr", mem_addr, 16'h0200);
    check("jack_fn_after", fetch_next, 1); advance();
    sample(); check("jack_iaddr", instr_addr, 16'h0200); advance();

    // Reset in the middle of a request.
    do_reset(16'h0031);
    mem_ack = 1'b0; instr_ready = 1'b1;
    cyc();
    sample(); check("mid_req", mem_req, 1); check("mid_addr", mem_addr, 16'h0030); advance();
    reset = 1'b1;
    sample(); check("mid_rst_req_now", mem_req, 0); advance();
    sample(); check("mid_rst_valid", instr_valid, 0); check("mid_rst_instr", instr, 0);
    check("mid_rst_iaddr", instr_addr, 0); advance();
    reset = 1'b0;
    sample(); check("mid_rel_idle", mem_req, 0); advance();
    sample(); check("mid_rel_req", mem_req, 1); check("mid_rel_addr", mem_addr, 16'h0030); advance();

    // Randomized traffic against the reference model.
    do_reset(16'($urandom));
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      mem_ack     = ($urandom_range(0, 9) < 7);
      instr_ready = ($urandom_range(0, 9) < 6);
      reset       = ($urandom_range(0, 299) == 0);
      jump        = ~reset & ($urandom_range(0, 39) == 0);
      jump_target = 16'($urandom);
      cyc();
    end
    reset = 1'b0; jump = 1'b0;
    check("rand_progress", consumed > 500, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shrimp_instruction_fetch.md
SHRIMP_INSTRUCTION_FETCH -- requirements
Module: shrimp_instruction_fetch

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
REQ-002: clock  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous active-high reset.
REQ-004: instruction_address  input  16  current PC from the instruction counter.
REQ-005: jump  input  1  redirect strobe; the same signal drives the counter's jump.
REQ-006: fetch_next  output  1  one-cycle strobe telling the counter to advance by 2.
REQ-007: mem_req  output  1  instruction memory read request.
REQ-008: mem_addr  output  16  read address, word-aligned.
REQ-009: mem_ack  input  1  memory accepted the request and returns data this cycle.
REQ-010: mem_rdata  input  16  read data, valid only while mem_req & mem_ack.
REQ-011: instr  output  16  instruction at the buffer head.
REQ-012: instr_addr  output  16  address of instr.
REQ-013: instr_valid  output  1  buffer head holds a valid instruction.
REQ-014: instr_ready  input  1  decoder accepts the head when instr_valid is also high.

Function
REQ-015: mem_addr SHALL be {instruction_address[15:1], 1'b0}; bit 0 is ignored.
REQ-016: The state machine SHALL have three states: IDLE (no request), REQ (mem_req=1), DISCARD (mem_req=1, returned data dropped).
REQ-017: Once raised, mem_req SHALL stay high, with mem_addr stable, until the cycle with mem_ack=1; a request is never retracted.
REQ-018: A fetch SHALL complete on any cycle with mem_req & mem_ack.
- In REQ without jump: push {mem_addr, mem_rdata} into a 2-entry buffer and assert fetch_next combinationally that cycle.
REQ-019: fetch_next SHALL be mem_req & mem_ack & (state==REQ) & ~jump; it is never high otherwise.
REQ-020: A new request SHALL be issued only while (buffer occupancy after this cycle's push and pop) < 2.
- With zero-wait memory and a ready decoder, throughput is 1 instruction per cycle.
REQ-021: IDLE -> REQ when space exists and jump=0.
- REQ -> IDLE on ack when the buffer becomes full.
- REQ stays in REQ on ack with space remaining.
REQ-022: jump SHALL flush the buffer at the next edge; instr_valid is 0 the following cycle.
- A decoder transfer on the jump cycle itself still counts as consumed.
REQ-023: On jump with state==REQ and mem_ack=0: go to DISCARD.
- On jump together with mem_ack: data dropped, next state REQ.
- On jump in IDLE: next state REQ.
REQ-024: DISCARD SHALL hold mem_req until mem_ack, drop the data, assert no fetch_next, then go to REQ.
- A further jump while in DISCARD has no extra effect.
REQ-025: The buffer SHALL be FIFO ordered; instr/instr_addr change only on pop, push-into-empty, or flush.
- Push and pop in the same cycle keep occupancy unchanged.
REQ-026: Latency: with mem_ack tied high, the first mem_req is asserted the cycle after reset deasserts; instr_valid follows one cycle later.

Reset
REQ-027: Reset SHALL force IDLE, an empty buffer, and outputs mem_req=0, fetch_next=0, instr_valid=0, instr=16'h0000, instr_addr=16'h0000.
REQ-028: Reset mid-request SHALL drop mem_req immediately, discard outstanding data and override jump.
- A memory that needs request completion is reset together with this block.

Structure
REQ-029: The shared package shrimp_pkg SHALL hold the addr_t and instr_t (16-bit) typedefs, the fetch_state_t enum {IDLE, REQ, DISCARD} and FETCH_DEPTH=2.
REQ-030: The buffer SHALL be a sub-module, shrimp_fetch_buffer.
- Ports: push, pop, flush, occupancy count, head data and address.

Verification
REQ-031: Reset, then mem_ack=1, instr_ready=1, counter model at PC=0 -> instr_addr sequence 0,2,4,6 on consecutive cycles, with fetch_next high every cycle.
REQ-032: instr_ready=0, mem_ack=1 -> exactly 2 fetches (addr 0,2), then mem_req=0, instr_valid stays 1, instr=mem[0] held.
REQ-033: mem_ack delayed 3 cycles, addr 16'h0010 -> mem_req and mem_addr=16'h0010 stable for all 3 cycles; one push on the ack cycle.
REQ-034: jump to 120 while a request is outstanding (no ack) -> DISCARD, ack data dropped, no fetch_next, next instr_addr=120.
REQ-035: jump on the same cycle as mem_ack with the buffer holding 1 entry -> buffer empty next cycle, fetch_next=0, next fetch from the jump address.
REQ-036: Reset asserted mid-request with instruction_address=16'h0031 before reset -> all outputs zero; after release the first mem_addr is 16'h0030.
